// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//
// Producer side of the KxK convolution core interface. A raster-order pixel
// stream passes through K-1 line buffers and a KxK window register. Only
// fully valid windows (unpadded, stride 1) are presented to the conv core.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   pix_in      incoming pixel (IMA bits, unsigned)
//   pix_valid   pixel accepted this cycle (no backpressure)
//   pix_sof     with pix_valid: this pixel is row 0, col 0 of a new frame
//   ima         packed window; slice i holds pixel r=i/K, c=i%K, r=0 top, c=0 left
//   enable      one-cycle strobe, ima holds a complete window
//   win_row     output-map row of the current window
//   win_col     output-map column of the current window
//   frame_done  one-cycle pulse with the last window of a frame
//   win_cnt     (WIN_COUNT_EN only) enables emitted so far in this frame
//
// Optional feature macro: WIN_COUNT_EN adds the win_cnt output and its counter.

module conv_window_feeder #(
  parameter int unsigned IMA   = 8,
  parameter int unsigned K     = 7,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IMA-1:0]       pix_in,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  output logic [IMA*K*K-1:0]   ima,
  output logic                 enable,
  output logic [CNT_W-1:0]     win_row,
  output logic [CNT_W-1:0]     win_col,
  output logic                 frame_done
`ifdef WIN_COUNT_EN
  ,
  output logic [CNT_W-1:0]     win_cnt
`endif
);

  localparam int unsigned NWin = K * K;
  localparam logic [CNT_W-1:0] KMinus1 = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] ColLast = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] RowLast = CNT_W'(IMG_H - 1);

  // Line buffers as shift chains; element IMG_W-1 of chain n holds the pixel
  // n+1 rows above the incoming one, same column.
  logic [IMA-1:0] lb_q  [K-1][IMG_W];
  logic [IMA-1:0] lb_in [K-1];

  always_comb begin
    lb_in[0] = pix_in;
    for (int n = 1; n < int'(K) - 1; n++) begin
      lb_in[n] = lb_q[n-1][IMG_W-1];
    end
  end

  // Contents are not reset: stale data never reaches an enabled window.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      for (int n = 0; n < int'(K) - 1; n++) begin
        lb_q[n][0] <= lb_in[n];
        for (int j = 1; j < int'(IMG_W); j++) begin
          lb_q[n][j] <= lb_q[n][j-1];
        end
      end
    end
  end

  // Window register
  logic [IMA-1:0] win_q [NWin];
  logic [IMA-1:0] win_d [NWin];

  always_comb begin
    win_d = win_q;
    if (pix_valid) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win_d[r*K + c] = win_q[r*K + c + 1];
        end
      end
      // Rightmost column: oldest line buffer at the top, pix_in at the bottom.
      for (int r = 0; r < int'(K) - 1; r++) begin
        win_d[r*K + K - 1] = lb_q[K-2-r][IMG_W-1];
      end
      win_d[NWin-1] = pix_in;
    end
  end

  always_comb begin
    ima = '0;
    for (int i = 0; i < int'(NWin); i++) begin
      ima[i*IMA +: IMA] = win_q[i];
    end
  end

  // Position counters (position of the next pixel to arrive)
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0] cur_row, cur_col;
  logic [CNT_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic             enable_q, enable_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    // A sof pixel overrides whatever position the counters hold.
    cur_row = pix_sof ? '0 : row_q;
    cur_col = pix_sof ? '0 : col_q;

    row_d = row_q;
    col_d = col_q;
    if (pix_valid) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end

    enable_d     = pix_valid && (cur_row >= KMinus1) && (cur_col >= KMinus1);
    frame_done_d = enable_d && (cur_row == RowLast) && (cur_col == ColLast);
    win_row_d    = enable_d ? cur_row - KMinus1 : win_row_q;
    win_col_d    = enable_d ? cur_col - KMinus1 : win_col_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      for (int i = 0; i < int'(NWin); i++) begin
        win_q[i] <= '0;
      end
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      for (int i = 0; i < int'(NWin); i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign enable     = enable_q;
  assign frame_done = frame_done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

`ifdef WIN_COUNT_EN
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (pix_valid && pix_sof) begin
      win_cnt_d = '0;
    end else if (frame_done_q) begin
      // Previous frame finished last cycle: restart the count.
      win_cnt_d = enable_d ? CNT_W'(1) : '0;
    end else if (enable_d) begin
      win_cnt_d = win_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: random pixel gaps and images,
// compared against windows cut directly out of a reference image array.
module tb_conv_window_feeder;

  localparam int unsigned IMA  = 8;
  localparam int unsigned K    = 7;
  localparam int unsigned W    = 28;
  localparam int unsigned H    = 28;
  localparam int unsigned CW   = 16;
  localparam int unsigned OW   = W - K + 1;
  localparam int unsigned OH   = H - K + 1;
  localparam int unsigned NPIX = W * H;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [IMA-1:0]       pix_in;
  logic                 pix_valid;
  logic                 pix_sof;
  logic [IMA*K*K-1:0]   ima;
  logic                 enable;
  logic [CW-1:0]        win_row;
  logic [CW-1:0]        win_col;
  logic                 frame_done;
`ifdef WIN_COUNT_EN
  logic [CW-1:0]        win_cnt;
`endif

  conv_window_feeder #(
    .IMA   (IMA),
    .K     (K),
    .IMG_W (W),
    .IMG_H (H),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .ima        (ima),
    .enable     (enable),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
`ifdef WIN_COUNT_EN
    ,
    .win_cnt    (win_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_errors  = 0;
  logic [7:0] img [H][W];
  int         duty      = 100;
  int         en_seen   = 0;
  int         fd_seen   = 0;
  bit         chk_first = 1'b0;
  bit         prev_fd   = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_pattern(input bit inv);
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        img[r][c] = 8'((r * W + c) & 255) ^ (inv ? 8'hFF : 8'h00);
  endtask

  task automatic fill_random();
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        img[r][c] = 8'($urandom_range(255));
  endtask

  // One clock: drive inputs, take the edge, check outputs 1 time unit later.
  task automatic step(input bit v, input bit s, input logic [7:0] p,
                      input bit en, input int wr, input int wc);
    logic [IMA*K*K-1:0] exp_win;
    bit                 last;
    pix_valid = v;
    pix_sof   = s;
    pix_in    = p;
    @(posedge clk);
    #1;
    last = en && (wr == int'(OH) - 1) && (wc == int'(OW) - 1);
    check("enable", enable, en);
    if (enable) en_seen++;
    if (frame_done) fd_seen++;
    if (en) begin
      for (int i = 0; i < int'(K * K); i++)
        exp_win[i*IMA +: IMA] = img[wr + i / K][wc + i % K];
      check("ima", ima, exp_win);
      check("win_row", win_row, wr);
      check("win_col", win_col, wc);
      check("frame_done", frame_done, last);
      if (chk_first && wr == 0 && wc == 0) begin
        check("first_s0", ima[7:0], 8'h00);
        check("first_s6", ima[55:48], 8'h06);
        check("first_s42", ima[343:336], 8'hA8);
        check("first_s48", ima[391:384], 8'hAE);
      end
    end else begin
      check("frame_done_idle", frame_done, 0);
    end
`ifdef WIN_COUNT_EN
    if (en) check("win_cnt", win_cnt, wr * int'(OW) + wc + 1);
    else if (prev_fd) check("win_cnt_clear", win_cnt, 0);
`endif
    prev_fd = last;
  endtask

  task automatic send_pix(input int r, input int c, input bit sof);
    while (duty < 100 && $urandom_range(99) >= duty)
      step(1'b0, 1'($urandom_range(1)), 8'($urandom_range(255)), 1'b0, 0, 0);
    step(1'b1, sof, img[r][c], (r >= int'(K) - 1) && (c >= int'(K) - 1),
         r - int'(K) + 1, c - int'(K) + 1);
  endtask

  task automatic send_frame(input bit sof_first, input int stop);
    for (int idx = 0; idx < stop; idx++)
      send_pix(idx / int'(W), idx % int'(W), sof_first && idx == 0);
  endtask

  int en0, fd0;

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_enable", enable, 0);
    check("rst_ima", ima, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_frame_done", frame_done, 0);
`ifdef WIN_COUNT_EN
    check("rst_win_cnt", win_cnt, 0);
`endif
    rst = 1'b0;

    // Clean pattern frame, continuous valid
    fill_pattern(1'b0);
    duty = 100; chk_first = 1'b1; en0 = en_seen; fd0 = fd_seen;
    send_frame(1'b1, NPIX);
    check("t1_enables", en_seen - en0, OW * OH);
    check("t1_frame_done", fd_seen - fd0, 1);

    // Same frame, 50% valid duty
    duty = 50; en0 = en_seen; fd0 = fd_seen;
    send_frame(1'b1, NPIX);
    check("t2_enables", en_seen - en0, OW * OH);
    check("t2_frame_done", fd_seen - fd0, 1);
    chk_first = 1'b0;

    // Random image, sparse valid, counters carry over without sof
    fill_random();
    duty = 30; en0 = en_seen; fd0 = fd_seen;
    send_frame(1'b0, NPIX);
    check("t3_enables", en_seen - en0, OW * OH);
    check("t3_frame_done", fd_seen - fd0, 1);

    // sof at pixel (15,10) abandons the partial frame
    fill_random();
    duty = 60; fd0 = fd_seen;
    send_frame(1'b1, 15 * W + 10);
    check("t4_partial_fd", fd_seen - fd0, 0);
    fill_pattern(1'b0);
    chk_first = 1'b1; en0 = en_seen; fd0 = fd_seen;
    send_frame(1'b1, NPIX);
    chk_first = 1'b0;
    check("t4_enables", en_seen - en0, OW * OH);
    check("t4_frame_done", fd_seen - fd0, 1);

    // Reset mid-frame at pixel (10,10)
    fill_random();
    duty = 50;
    send_frame(1'b0, 10 * W + 10);
    rst = 1'b1; pix_valid = 1'b1; pix_sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_in = 8'($urandom_range(255));
      #1;
      check("rst_mid_enable", enable, 0);
      check("rst_mid_ima", ima, 0);
      check("rst_mid_fd", frame_done, 0);
      check("rst_mid_row", win_row, 0);
`ifdef WIN_COUNT_EN
      check("rst_mid_win_cnt", win_cnt, 0);
`endif
      @(posedge clk);
      #1;
    end
    rst = 1'b0; prev_fd = 1'b0;
    fill_pattern(1'b0);
    chk_first = 1'b1; en0 = en_seen; fd0 = fd_seen;
    send_frame(1'b0, NPIX);
    chk_first = 1'b0;
    check("t5_enables", en_seen - en0, OW * OH);
    check("t5_frame_done", fd_seen - fd0, 1);

    // Back-to-back frames, second is the inverse of the first
    duty = 100; en0 = en_seen; fd0 = fd_seen;
    fill_pattern(1'b0);
    send_frame(1'b1, NPIX);
    fill_pattern(1'b1);
    send_frame(1'b1, NPIX);
    step(1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
    check("t6_enables", en_seen - en0, 2 * OW * OH);
    check("t6_frame_done", fd_seen - fd0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
